// File: rtl/est_pkg.sv
// Shared types and arithmetic helpers for the streaming estimation engine.
package est_pkg;

  typedef enum logic [2:0] {IDLE, WAIT_Z, MAC, OUT, DONE} est_state_t;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } sat_res_t;

  // Accumulator width that cannot overflow for a DIM-term dot product.
  function automatic int acc_width(input int dw, input int dim);
    return 2 * dw + $clog2(dim) + 1;
  endfunction

  // Round (optional half-up), arithmetic shift by fw, clamp to a dw-bit signed range.
  function automatic sat_res_t sat_round(input logic signed [63:0] acc, input int dw,
                                         input int fw, input logic rnd);
    sat_res_t           r;
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh    = (acc + ((rnd && fw > 0) ? (64'sd1 <<< (fw - 1)) : 64'sd0)) >>> fw;
    hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (dw - 1));
    r.ovf = (sh > hi) || (sh < lo);
    r.val = (sh > hi) ? hi : ((sh < lo) ? lo : sh);
    return r;
  endfunction

endpackage

// File: rtl/est_mac_lanes.sv
// LANES signed multipliers summed into one chunk result; purely combinational.
module est_mac_lanes
  import est_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 1,
  parameter int SUM_WIDTH  = acc_width(16, 3)
) (
  input  logic signed [DATA_WIDTH-1:0] w_i [LANES],
  input  logic signed [DATA_WIDTH-1:0] z_i [LANES],
  output logic signed [SUM_WIDTH-1:0]  sum_o
);

  logic signed [2*DATA_WIDTH-1:0] prod [LANES];

  always_comb begin
    sum_o = '0;
    for (int l = 0; l < LANES; l++) begin
      prod[l] = w_i[l] * z_i[l];
      sum_o   = sum_o + SUM_WIDTH'(prod[l]);
    end
  end

endmodule

// File: rtl/est_stream_engine.sv
// Streaming S = W*Z engine: one sample in, DIM*K MAC cycles, one rounded/saturated vector out.
module est_stream_engine
  import est_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 14,
  parameter int DIM        = 3,
  parameter int LANES      = 1,
  parameter int CNT_WIDTH  = 16,
  parameter int ROUND_EN   = 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             en,
  input  logic [CNT_WIDTH-1:0]             num_samples,
  input  logic [DATA_WIDTH*DIM*DIM-1:0]    W_MAT,
  input  logic                             z_vld,
  output logic                             z_rdy,
  input  logic [DATA_WIDTH*DIM-1:0]        z_in,
  output logic                             s_vld,
  input  logic                             s_rdy,
  output logic [DATA_WIDTH*DIM-1:0]        s_out,
  output logic                             s_last,
  output logic                             est_opvld,
  output logic                             sat_flag,
  output est_state_t                       dbg_state
);

  localparam int K     = (DIM + LANES - 1) / LANES;
  localparam int ROW_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CHK_W = (K > 1) ? $clog2(K) : 1;
  localparam int ACC_W = acc_width(DATA_WIDTH, DIM);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // s_vld/s_out/s_last never change while s_vld=1 and s_rdy=0.

  est_state_t                  state_q, state_d;
  logic signed [DATA_WIDTH-1:0] w_q [DIM*DIM];
  logic signed [DATA_WIDTH-1:0] w_d [DIM*DIM];
  logic signed [DATA_WIDTH-1:0] z_q [DIM];
  logic signed [DATA_WIDTH-1:0] z_d [DIM];
  logic signed [DATA_WIDTH-1:0] s_q [DIM];
  logic signed [DATA_WIDTH-1:0] s_d [DIM];
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic [CHK_W-1:0]             chk_q, chk_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]         num_q, num_d;
  logic                         sat_q, sat_d;

  logic signed [DATA_WIDTH-1:0] w_lane [LANES];
  logic signed [DATA_WIDTH-1:0] z_lane [LANES];
  logic signed [ACC_W-1:0]      chunk_sum;
  logic signed [ACC_W-1:0]      acc_sum;
  sat_res_t                     res;
  logic                         last_sample;
  logic                         unused_res_hi;

  // Lanes whose column index falls past DIM match nothing and stay zero.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane[l] = '0;
      z_lane[l] = '0;
      for (int k = 0; k < DIM; k++) begin
        if (int'(chk_q) * LANES + l == k) begin
          z_lane[l] = z_q[k];
          for (int r = 0; r < DIM; r++) begin
            if (int'(row_q) == r) w_lane[l] = w_q[r*DIM+k];
          end
        end
      end
    end
  end

  est_mac_lanes #(
    .DATA_WIDTH(DATA_WIDTH),
    .LANES     (LANES),
    .SUM_WIDTH (ACC_W)
  ) u_mac (
    .w_i  (w_lane),
    .z_i  (z_lane),
    .sum_o(chunk_sum)
  );

  assign acc_sum       = acc_q + chunk_sum;
  assign res           = sat_round(64'(acc_sum), DATA_WIDTH, FRAC_WIDTH, ROUND_EN != 0);
  // Bits above DATA_WIDTH are sign copies once clamped.
  assign unused_res_hi = ^res.val[63:DATA_WIDTH];
  assign last_sample   = ({1'b0, cnt_q} + (CNT_WIDTH+1)'(1)) == {1'b0, num_q};

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    z_d     = z_q;
    s_d     = s_q;
    acc_d   = acc_q;
    row_d   = row_q;
    chk_d   = chk_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          for (int i = 0; i < DIM*DIM; i++) begin
            w_d[i] = W_MAT[(DIM*DIM-1-i)*DATA_WIDTH +: DATA_WIDTH];
          end
          num_d   = num_samples;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = (num_samples == '0) ? DONE : WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (z_vld) begin
          for (int i = 0; i < DIM; i++) begin
            z_d[i] = z_in[(DIM-1-i)*DATA_WIDTH +: DATA_WIDTH];
          end
          acc_d   = '0;
          row_d   = '0;
          chk_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        if (chk_q == CHK_W'(K - 1)) begin
          acc_d = '0;
          chk_d = '0;
          for (int r = 0; r < DIM; r++) begin
            if (int'(row_q) == r) s_d[r] = res.val[DATA_WIDTH-1:0];
          end
          if (res.ovf) sat_d = 1'b1;
          if (row_q == ROW_W'(DIM - 1)) state_d = OUT;
          else                          row_d   = row_q + 1'b1;
        end else begin
          chk_d = chk_q + 1'b1;
        end
      end
      OUT: begin
        if (s_rdy) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = last_sample ? DONE : WAIT_Z;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      for (int i = 0; i < DIM*DIM; i++) w_q[i] <= '0;
      for (int i = 0; i < DIM; i++) begin
        z_q[i] <= '0;
        s_q[i] <= '0;
      end
      acc_q <= '0;
      row_q <= '0;
      chk_q <= '0;
      cnt_q <= '0;
      num_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      z_q     <= z_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      sat_q   <= sat_d;
    end
  end

  assign z_rdy     = (state_q == WAIT_Z);
  assign s_vld     = (state_q == OUT);
  assign s_last    = (state_q == OUT) && last_sample;
  assign est_opvld = (state_q == DONE);
  assign sat_flag  = sat_q;
  assign dbg_state = state_q;

  for (genvar g = 0; g < DIM; g++) begin : g_sout
    assign s_out[(DIM-1-g)*DATA_WIDTH +: DATA_WIDTH] = s_q[g];
  end

endmodule

// File: tb/tb_est_stream_engine.sv
// Directed bench for est_stream_engine: one LANES=1/round and one LANES=3/truncate instance.
module tb_est_stream_engine;
  import est_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic         en_a, en_b;
  logic [15:0]  num_a;
  logic [2:0]   num_b;
  logic [143:0] w_mat;
  logic         z_vld;
  logic [47:0]  z_in;
  logic         s_rdy;

  logic         z_rdy_a, s_vld_a, s_last_a, opvld_a, sat_a;
  logic [47:0]  s_out_a;
  est_state_t   dbg_a;
  logic         z_rdy_b, s_vld_b, s_last_b, opvld_b, sat_b;
  logic [47:0]  s_out_b;
  est_state_t   dbg_b;

  logic         sel;
  logic         m_z_rdy, m_s_vld, m_s_last, m_opvld, m_sat;
  logic [47:0]  m_s_out;
  assign m_z_rdy  = sel ? z_rdy_b  : z_rdy_a;
  assign m_s_vld  = sel ? s_vld_b  : s_vld_a;
  assign m_s_last = sel ? s_last_b : s_last_a;
  assign m_opvld  = sel ? opvld_b  : opvld_a;
  assign m_sat    = sel ? sat_b    : sat_a;
  assign m_s_out  = sel ? s_out_b  : s_out_a;

  est_stream_engine #(.DATA_WIDTH(16), .FRAC_WIDTH(14), .DIM(3), .LANES(1),
                      .CNT_WIDTH(16), .ROUND_EN(1)) dut_a (
    .clk(clk), .rstn(rstn), .en(en_a), .num_samples(num_a), .W_MAT(w_mat),
    .z_vld(z_vld), .z_rdy(z_rdy_a), .z_in(z_in), .s_vld(s_vld_a), .s_rdy(s_rdy),
    .s_out(s_out_a), .s_last(s_last_a), .est_opvld(opvld_a), .sat_flag(sat_a),
    .dbg_state(dbg_a));

  est_stream_engine #(.DATA_WIDTH(16), .FRAC_WIDTH(14), .DIM(3), .LANES(3),
                      .CNT_WIDTH(3), .ROUND_EN(0)) dut_b (
    .clk(clk), .rstn(rstn), .en(en_b), .num_samples(num_b), .W_MAT(w_mat),
    .z_vld(z_vld), .z_rdy(z_rdy_b), .z_in(z_in), .s_vld(s_vld_b), .s_rdy(s_rdy),
    .s_out(s_out_b), .s_last(s_last_b), .est_opvld(opvld_b), .sat_flag(sat_b),
    .dbg_state(dbg_b));

  int n_checks = 0;
  int n_errors = 0;
  logic [47:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] v3(input int a, input int b, input int c);
    return {a[15:0], b[15:0], c[15:0]};
  endfunction

  typedef struct {
    bit           sel;
    logic [143:0] w;
    logic [47:0]  z;
    logic [47:0]  s;
    bit           sat;
    int           lat;
  } vec_t;

  // Single-sample run; checks latency, data, s_last, sat_flag and the est_opvld pulse.
  task automatic run_one(input string name, input vec_t v);
    int   n;
    logic o1, o2;
    sel = v.sel;
    @(negedge clk);
    w_mat = v.w; num_a = 16'd1; num_b = 3'd1;
    if (v.sel) en_b = 1'b1; else en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0; en_b = 1'b0;
    z_in = v.z; z_vld = 1'b1;
    n = 0;
    while (!m_z_rdy && n < 20) begin @(negedge clk); n++; end
    chk({name, " z_rdy"}, m_z_rdy, 1);
    @(negedge clk);
    z_vld = 1'b0;
    n = 1;
    while (!m_s_vld && n < 50) begin @(negedge clk); n++; end
    chk({name, " latency"}, n, v.lat);
    chk({name, " s_out"}, m_s_out, v.s);
    chk({name, " s_last"}, m_s_last, 1);
    chk({name, " sat_flag"}, m_sat, v.sat);
    @(negedge clk);
    o1 = m_opvld;
    @(negedge clk);
    o2 = m_opvld;
    chk({name, " opvld_pulse"}, {o1, o2}, 2'b10);
    chk({name, " sat_sticky"}, m_sat, v.sat);
  endtask

  vec_t         vecs[8];
  logic [143:0] w_id, w_rnd, w_max, w_s;
  logic [47:0]  zs[4];
  logic [47:0]  es[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; en_a = 1'b0; en_b = 1'b0; num_a = '0; num_b = '0;
    w_mat = '0; z_vld = 1'b0; z_in = '0; s_rdy = 1'b1; sel = 1'b0;

    w_id  = {v3(16384, 0, 0), v3(0, 16384, 0), v3(0, 0, 16384)};
    w_rnd = {v3(8192, 0, 0), v3(0, 0, 0), v3(0, 0, 0)};
    w_max = {9{16'h7FFF}};
    vecs[0] = '{0, w_id, v3(1000, -2000, 3000), v3(1000, -2000, 3000), 0, 10};
    vecs[1] = '{1, {v3(8192, 8192, 0), v3(0, 16384, -16384), v3(16384, 16384, 16384)},
                v3(100, 200, 300), v3(150, -100, 600), 0, 4};
    vecs[2] = '{0, w_max, {3{16'h7FFF}}, {3{16'h7FFF}}, 1, 10};
    vecs[3] = '{0, w_max, {3{16'h8000}}, {3{16'h8000}}, 1, 10};
    vecs[4] = '{0, w_rnd, v3(-3, 5, 7), v3(-1, 0, 0), 0, 10};
    vecs[5] = '{0, w_rnd, v3(3, -9, 1), v3(2, 0, 0), 0, 10};
    vecs[6] = '{1, w_rnd, v3(-3, 0, 0), v3(-2, 0, 0), 0, 4};
    vecs[7] = '{1, w_rnd, v3(3, 0, 0), v3(1, 0, 0), 0, 4};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outs_a", {z_rdy_a, s_vld_a, s_last_a, opvld_a, sat_a, s_out_a}, '0);
    chk("reset_outs_b", {z_rdy_b, s_vld_b, s_last_b, opvld_b, sat_b, s_out_b}, '0);
    chk("reset_state_a", dbg_a, IDLE);
    chk("reset_state_b", dbg_b, IDLE);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_one($sformatf("vec%0d", i), vecs[i]);

    // Zero-length run
    begin
      logic seen;
      sel = 1'b0;
      @(negedge clk);
      num_a = 16'd0; en_a = 1'b1;
      @(negedge clk);
      en_a = 1'b0;
      chk("zero_opvld", opvld_a, 1);
      seen = s_vld_a;
      @(negedge clk);
      chk("zero_opvld_end", opvld_a, 0);
      repeat (4) begin seen |= s_vld_a; @(negedge clk); end
      chk("zero_no_svld", seen, 0);
    end

    // Streamed run with random backpressure and random z_vld gaps
    begin
      int n_out, n_opv, stab_err, zr_err, p_n;
      logic prev_stall;
      logic [47:0] prev_out, exp_v;
      w_s   = {v3(16384, 0, 0), v3(8192, 8192, 0), v3(0, 0, -16384)};
      zs[0] = v3(10, 20, 30);        es[0] = v3(10, 15, -30);
      zs[1] = v3(-7, 5, 1);          es[1] = v3(-7, -1, -1);
      zs[2] = v3(100, -101, 0);      es[2] = v3(100, 0, 0);
      zs[3] = v3(32767, 32767, -32768); es[3] = v3(32767, 32767, 32767);
      for (int i = 0; i < 4; i++) exp_q.push_back(es[i]);
      n_out = 0; n_opv = 0; stab_err = 0; zr_err = 0; prev_stall = 1'b0; prev_out = '0;
      sel = 1'b0;
      @(negedge clk);
      w_mat = w_s; num_a = 16'd4; en_a = 1'b1;
      @(negedge clk);
      en_a = 1'b0;
      fork
        begin
          for (int i = 0; i < 4; i++) begin
            z_vld = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            z_vld = 1'b1; z_in = zs[i];
            p_n = 0;
            while (!z_rdy_a && p_n < 200) begin @(negedge clk); p_n++; end
            @(negedge clk);
          end
          z_vld = 1'b0;
        end
        begin
          for (int c = 0; c < 300; c++) begin
            s_rdy = 1'($urandom_range(0, 1));
            if (prev_stall && (!s_vld_a || s_out_a !== prev_out)) stab_err++;
            if (z_rdy_a && s_vld_a) zr_err++;
            if (z_rdy_a !== (dbg_a == WAIT_Z)) zr_err++;
            if (opvld_a) n_opv++;
            if (s_vld_a && s_rdy) begin
              if (exp_q.size() == 0) begin
                chk("stream_extra_out", 1, 0);
              end else begin
                exp_v = exp_q.pop_front();
                chk($sformatf("stream_out%0d", n_out), s_out_a, exp_v);
                chk($sformatf("stream_last%0d", n_out), s_last_a, exp_q.size() == 0);
              end
              n_out++;
            end
            prev_stall = s_vld_a && !s_rdy;
            prev_out   = s_out_a;
            @(negedge clk);
          end
        end
      join
      s_rdy = 1'b1;
      chk("stream_count", n_out, 4);
      chk("stream_opvld_count", n_opv, 1);
      chk("stream_stable", stab_err, 0);
      chk("stream_z_rdy", zr_err, 0);
      chk("stream_sat", sat_a, 1);
    end

    // Full-scale count on the 3-bit counter, plus an en pulse mid-run that must be ignored
    begin
      int n_out, n_last, last_at, n_opv, d_err;
      n_out = 0; n_last = 0; last_at = 0; n_opv = 0; d_err = 0;
      sel = 1'b1;
      @(negedge clk);
      w_mat = w_id; num_b = 3'd7; en_b = 1'b1;
      @(negedge clk);
      en_b = 1'b0; z_in = v3(5, -6, 7); z_vld = 1'b1;
      for (int c = 0; c < 100; c++) begin
        en_b = (c == 10);
        if (c == 10) num_b = 3'd2;
        if (opvld_b) n_opv++;
        if (s_vld_b) begin
          n_out++;
          if (s_out_b !== v3(5, -6, 7)) d_err++;
          if (s_last_b) begin n_last++; last_at = n_out; end
        end
        @(negedge clk);
      end
      en_b = 1'b0; z_vld = 1'b0;
      chk("maxcnt_outputs", n_out, 7);
      chk("maxcnt_last", {n_last[7:0], last_at[7:0]}, {8'd1, 8'd7});
      chk("maxcnt_opvld", n_opv, 1);
      chk("maxcnt_data", d_err, 0);
    end

    // Asynchronous reset in the middle of a MAC sequence
    begin
      logic bad;
      sel = 1'b0;
      @(negedge clk);
      w_mat = w_max; num_a = 16'd1; en_a = 1'b1;
      @(negedge clk);
      en_a = 1'b0; z_in = {3{16'h7FFF}}; z_vld = 1'b1;
      @(negedge clk);
      z_vld = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_pre_state", dbg_a, MAC);
      chk("rst_pre_sat", sat_a, 1);
      #2 rstn = 1'b0;
      #1;
      chk("rst_async_outs", {z_rdy_a, s_vld_a, s_last_a, opvld_a, sat_a, s_out_a}, '0);
      chk("rst_async_state", dbg_a, IDLE);
      @(negedge clk);
      rstn = 1'b1;
      bad = 1'b0;
      repeat (6) begin bad |= opvld_a | z_rdy_a | s_vld_a; @(negedge clk); end
      chk("rst_stays_idle", bad, 0);
      run_one("post_rst", vecs[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
